core_inst_seq: RTL

- Upstream control stage that drives the core's 34-bit instruction bus and its D_xmem data bus for one full tile pass.
- It accepts a weight-plus-activation stream over valid/ready and writes it into the input SRAM.
- It then sequences kernel load, execution, and OFIFO drain into the output SRAM.
- It reports busy/done to the host testbench or top-level controller.

---
 rtl/core_inst_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/core_inst_seq.sv
// Tile-pass sequencer: streams weights/activations into xmem, then drives
// kernel load, execution and OFIFO drain into pmem over the core inst bus.
module core_inst_seq #(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int bw        = 4,
    parameter int a_len     = 36,
    parameter int drain_len = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              acc_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bw*row-1:0] in_data,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic [bw*row-1:0] D_xmem,
    output logic              busy,
    output logic              done
);

    localparam logic [10:0] x_last  = 11'(row + a_len - 1);
    localparam logic [10:0] k_last  = 11'(row);
    localparam logic [10:0] ke_last = 11'(row + col - 1);
    localparam logic [10:0] a_last  = 11'(a_len + row + col);
    localparam logic [10:0] a_words = 11'(a_len);
    localparam logic [10:0] row_c   = 11'(row);
    localparam logic [10:0] d_len   = 11'(drain_len);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        KLOAD,
        KEXEC,
        AEXEC,
        DRAIN
    } state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] pcnt;

    logic        acc_q;
    logic        cen_p;
    logic        wen_p;
    logic [10:0] a_p;
    logic        cen_x;
    logic        wen_x;
    logic [10:0] a_x;
    logic        ofifo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        exec_q;
    logic        load_q;

    assign inst = {acc_q, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                   ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, exec_q, load_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pcnt     <= '0;
            acc_q    <= 1'b0;
            cen_p    <= 1'b1;
            wen_p    <= 1'b1;
            a_p      <= '0;
            cen_x    <= 1'b1;
            wen_x    <= 1'b1;
            a_x      <= '0;
            ofifo_rd <= 1'b0;
            l0_rd    <= 1'b0;
            l0_wr    <= 1'b0;
            exec_q   <= 1'b0;
            load_q   <= 1'b0;
            in_ready <= 1'b0;
            D_xmem   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Strobes and addresses fall back to idle unless a state drives them
            cen_p    <= 1'b1;
            wen_p    <= 1'b1;
            a_p      <= '0;
            cen_x    <= 1'b1;
            wen_x    <= 1'b1;
            a_x      <= '0;
            ofifo_rd <= 1'b0;
            l0_rd    <= 1'b0;
            l0_wr    <= 1'b0;
            exec_q   <= 1'b0;
            load_q   <= 1'b0;
            done     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_X;
                        acc_q    <= acc_mode;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        pcnt     <= '0;
                    end
                end

                LOAD_X: begin
                    if (in_valid && in_ready) begin
                        D_xmem <= in_data;
                        cen_x  <= 1'b0;
                        wen_x  <= 1'b0;
                        a_x    <= cnt;
                        if (cnt == x_last) begin
                            state    <= KLOAD;
                            in_ready <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end

                KLOAD: begin
                    if (cnt < row_c) begin
                        cen_x <= 1'b0;
                        a_x   <= cnt;
                    end
                    // read data lands one cycle after its address
                    l0_wr <= (cnt != 11'd0);
                    if (cnt == k_last) begin
                        state <= KEXEC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                KEXEC: begin
                    l0_rd  <= 1'b1;
                    load_q <= 1'b1;
                    if (cnt == ke_last) begin
                        state <= AEXEC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                AEXEC: begin
                    if (cnt < a_words) begin
                        cen_x <= 1'b0;
                        a_x   <= row_c + cnt;
                    end
                    l0_wr  <= (cnt != 11'd0) && (cnt <= a_words);
                    l0_rd  <= (cnt != 11'd0);
                    exec_q <= (cnt != 11'd0);
                    if (cnt == a_last) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        pcnt  <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                DRAIN: begin
                    // cnt counts OFIFO reads, pcnt counts pmem writes
                    if (ofifo_valid && (cnt < d_len)) begin
                        ofifo_rd <= 1'b1;
                        cnt      <= cnt + 11'd1;
                    end
                    if (ofifo_rd) begin
                        cen_p <= 1'b0;
                        wen_p <= 1'b0;
                        a_p   <= pcnt;
                        pcnt  <= pcnt + 11'd1;
                    end
                    if (pcnt == d_len) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        acc_q <= 1'b0;
                        cnt   <= '0;
                        pcnt  <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
